db_bank: RTL and testbench
==========================

DB_BANK -- requirements
Module: db_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent push-button channels (1..16).
REQ-002 Parameter DELAY, default 15, consecutive stable cycles required to accept a level change (>=2).
REQ-003 Parameter REPEAT_START, default 1000, held cycles before first auto-repeat pulse (>=1).
REQ-004 Parameter REPEAT_PERIOD, default 250, cycles between subsequent auto-repeat pulses (>=1).
REQ-005 clk  input  1  base clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 pb  input  N_CH  raw asynchronous mechanical button levels, bit i = channel i.
REQ-008 status  output  N_CH  debounced level per channel, 1 = pressed.
REQ-009 pressed_pulse  output  N_CH  one-cycle pulse per accepted press.
REQ-010 released_pulse  output  N_CH  one-cycle pulse per accepted release.
REQ-011 repeat_pulse  output  N_CH  one-cycle auto-repeat pulse while held (see Configuration).
REQ-012 any_pressed  output  1  OR of all status bits.

Function
REQ-013 Each channel SHALL pass pb[i] through a two-flop synchronizer; sync[i] is the second flop output.
REQ-014 Each channel SHALL own a counter of width $clog2(DELAY+1); counter clears to 0 on any cycle where sync[i]==status[i].
REQ-015 While sync[i]!=status[i], counter SHALL increment by 1 per cycle; on the edge where counter==DELAY-1 and mismatch persists, status[i] SHALL toggle and counter SHALL clear.
REQ-016 Latency: pb[i] stable from edge k -> status[i] changes at edge k+1+DELAY (2 sync + DELAY-1 count edges); mismatch shorter than DELAY cycles SHALL produce no change.
REQ-017 All pulse outputs SHALL be registered, high exactly in the first cycle status[i] shows the new level; pressed on 0->1, released on 1->0; never both in one cycle on one channel.
REQ-018 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-019 Counters SHALL never wrap; DELAY-1 is the maximum value reached.
REQ-020 any_pressed SHALL be combinational from status, no extra latency.

Reset
REQ-021 rst low SHALL asynchronously clear synchronizer flops, counters, status, all pulse registers and hold counters; all outputs read 0 while rst is low.
REQ-022 Reset asserted mid-count or mid-hold SHALL abort that event with no pulse; after release a button still held is re-accepted as a new press after full latency (REQ-016).
REQ-023 Reset release SHALL be synchronous to clk by the surrounding system; block makes no assumption beyond that.

Configuration
REQ-024 Macro DB_BANK_AUTOREPEAT_EN defined: per-channel hold counter, width $clog2(max(REPEAT_START,REPEAT_PERIOD)+1), runs while status[i]==1, clears when status[i]==0.
REQ-025 With macro: repeat_pulse[i] high one cycle REPEAT_START cycles after pressed_pulse[i], then every REPEAT_PERIOD cycles until release; no repeat pulse in the release cycle or after.
REQ-026 Without macro: hold counters not instantiated, repeat_pulse SHALL be constant 0; all other behaviour unchanged.

Verification (N_CH=4, DELAY=4, REPEAT_START=10, REPEAT_PERIOD=5)
REQ-027 pb=4'b0001 from edge 10, held -> status[0]=1 and pressed_pulse[0]=1 at edge 15 only, any_pressed=1 from edge 15.
REQ-028 pb[1] pulses high 3 cycles, low 1, high 3 -> status[1] stays 0, no pulses.
REQ-029 pb=4'b1010 simultaneously, held then released together -> pressed_pulse=4'b1010 same cycle, later released_pulse=4'b1010 same cycle.
REQ-030 Macro on, pb[2] held 30 cycles after acceptance -> repeat_pulse[2] at +10, +15, +20, +25, +30 relative to pressed_pulse; none after release. Macro off -> repeat_pulse always 0.
REQ-031 rst low for 2 cycles while pb[3] mismatch counter=2 -> all outputs 0, no pulse; pb[3] still high -> pressed_pulse[3] DELAY+1 edges after rst release.

Source files
------------

// File: rtl/db_bank.sv
// Bank of independent push-button debouncers with press/release pulses.
// Optional auto-repeat when DB_BANK_AUTOREPEAT_EN is defined.
module db_bank #(
  parameter int N_CH          = 4,
  parameter int DELAY         = 15,
  parameter int REPEAT_START  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] status,
  output logic [N_CH-1:0] pressed_pulse,
  output logic [N_CH-1:0] released_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_pressed
);

  localparam int               CNT_W    = $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  logic [N_CH-1:0]  meta_q, sync_q;
  logic [N_CH-1:0]  status_q, status_d;
  logic [N_CH-1:0]  pressed_q, pressed_d;
  logic [N_CH-1:0]  released_q, released_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    status_d   = status_q;
    pressed_d  = '0;
    released_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != status_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          status_d[i]   = ~status_q[i];
          pressed_d[i]  = ~status_q[i];
          released_d[i] = status_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the counter
  // arrays are reset element by element because a held button must restart from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      status_q   <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q     <= pb;
      sync_q     <= meta_q;
      status_q   <= status_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign status         = status_q;
  assign pressed_pulse  = pressed_q;
  assign released_pulse = released_q;
  assign any_pressed    = |status_q;

`ifdef DB_BANK_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] START_LAST  = HOLD_W'(REPEAT_START - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] hold_q [N_CH];
  logic [HOLD_W-1:0] hold_d [N_CH];
  logic [N_CH-1:0]   started_q, started_d;
  logic [N_CH-1:0]   repeat_q, repeat_d;

  // started_q selects the first-delay limit versus the steady repeat period.
  always_comb begin
    started_d = '0;
    repeat_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      hold_d[i] = '0;
      if (status_q[i] && status_d[i]) begin
        if (hold_q[i] == (started_q[i] ? PERIOD_LAST : START_LAST)) begin
          repeat_d[i]  = 1'b1;
          started_d[i] = 1'b1;
        end else begin
          hold_d[i]    = hold_q[i] + HOLD_W'(1);
          started_d[i] = started_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
    end else begin
      started_q <= started_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_db_bank.sv
// Directed self-checking bench for db_bank (N_CH=4, DELAY=4, REPEAT_START=10, REPEAT_PERIOD=5).
module tb_db_bank;

  localparam int N_CH   = 4;
  localparam int DELAY  = 4;
  localparam int RSTART = 10;
  localparam int RPER   = 5;
`ifdef DB_BANK_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_CH-1:0] pb  = '0;
  logic [N_CH-1:0] status, pressed_pulse, released_pulse, repeat_pulse;
  logic            any_pressed;

  int total = 0;
  int bad   = 0;

  db_bank #(
    .N_CH(N_CH), .DELAY(DELAY), .REPEAT_START(RSTART), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk), .rst(rst), .pb(pb),
    .status(status), .pressed_pulse(pressed_pulse), .released_pulse(released_pulse),
    .repeat_pulse(repeat_pulse), .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // One rising edge, then settle at the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"},   32'(status), 32'h0);
    check({tag, "_pressed"},  32'(pressed_pulse), 32'h0);
    check({tag, "_released"}, 32'(released_pulse), 32'h0);
    check({tag, "_repeat"},   32'(repeat_pulse), 32'h0);
    check({tag, "_any"},      32'(any_pressed), 32'h0);
  endtask

  initial begin
    logic [6:0] glitch;
    bit         found;
    logic [3:0] exp_rep, exp_rel;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    repeat (3) tick();
    check("idle_status", 32'(status), 32'h0);

    // Single press on channel 0: stable from edge k, accepted at edge k+1+DELAY
    pb = 4'b0001;
    repeat (DELAY + 1) tick();
    check("p0_early_status", 32'(status), 32'h0);
    check("p0_early_pressed", 32'(pressed_pulse), 32'h0);
    tick();
    check("p0_status", 32'(status), 32'h1);
    check("p0_pressed", 32'(pressed_pulse), 32'h1);
    check("p0_any", 32'(any_pressed), 32'h1);
    tick();
    check("p0_pressed_off", 32'(pressed_pulse), 32'h0);
    check("p0_status_hold", 32'(status), 32'h1);
    pb = 4'b0000;
    repeat (DELAY + 1) tick();
    check("r0_early_released", 32'(released_pulse), 32'h0);
    check("r0_early_status", 32'(status), 32'h1);
    tick();
    check("r0_released", 32'(released_pulse), 32'h1);
    check("r0_status", 32'(status), 32'h0);
    check("r0_any", 32'(any_pressed), 32'h0);
    check("r0_pressed", 32'(pressed_pulse), 32'h0);
    tick();
    check("r0_released_off", 32'(released_pulse), 32'h0);

    // Bounce on channel 1: 3 high, 1 low, 3 high never reaches DELAY
    glitch = 7'b1110111;
    for (int i = 0; i < 15; i++) begin
      pb[1] = (i < 7) ? glitch[6 - i] : 1'b0;
      tick();
      check("glitch", {20'h0, status, pressed_pulse, released_pulse}, 32'h0);
    end

    // Simultaneous press and release on channels 1 and 3
    pb = 4'b1010;
    repeat (DELAY + 1) tick();
    check("m_early_pressed", 32'(pressed_pulse), 32'h0);
    tick();
    check("m_pressed", 32'(pressed_pulse), 32'ha);
    check("m_status", 32'(status), 32'ha);
    check("m_released_clear", 32'(released_pulse), 32'h0);
    repeat (3) tick();
    check("m_pressed_off", 32'(pressed_pulse), 32'h0);
    check("m_status_hold", 32'(status), 32'ha);
    pb = 4'b0000;
    repeat (DELAY + 1) tick();
    check("m_early_released", 32'(released_pulse), 32'h0);
    tick();
    check("m_released", 32'(released_pulse), 32'ha);
    check("m_released_status", 32'(status), 32'h0);
    check("m_released_pressed", 32'(pressed_pulse), 32'h0);
    check("m_released_any", 32'(any_pressed), 32'h0);
    tick();

    // Auto-repeat on channel 2; release lands exactly where a pulse at +35 would fall
    pb = 4'b0100;
    found = 1'b0;
    for (int n = 0; n < 12 && !found; n++) begin
      tick();
      if (pressed_pulse[2]) found = 1'b1;
    end
    check("rep_press_seen", 32'(found), 32'h1);
    for (int j = 1; j <= 40; j++) begin
      tick();
      exp_rep = (AUTOREP && j >= RSTART && j < 29 + DELAY + 2 && ((j - RSTART) % RPER) == 0)
                ? 4'b0100 : 4'b0000;
      exp_rel = (j == 29 + DELAY + 2) ? 4'b0100 : 4'b0000;
      check($sformatf("rep_j%0d", j), 32'(repeat_pulse), 32'(exp_rep));
      check($sformatf("rep_rel_j%0d", j), 32'(released_pulse), 32'(exp_rel));
      if (j == 29) pb = 4'b0000;
    end

    // Reset mid-count on channel 3 (counter at 2), then re-acceptance after release
    pb = 4'b1000;
    repeat (4) tick();
    check("rc_status_pre", 32'(status), 32'h0);
    rst = 1'b0;
    #1;
    check_all_zero("rc_async");
    repeat (2) begin
      tick();
      check_all_zero("rc_held");
    end
    rst = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      check($sformatf("rc_pressed_e%0d", e), 32'(pressed_pulse),
            (e == DELAY + 1) ? 32'h8 : 32'h0);
    end
    check("rc_status_post", 32'(status), 32'h8);
    check("rc_any_post", 32'(any_pressed), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
